// File: rtl/reconf_sequencer_if.sv
// Request/launch bundle between the reconfiguration requester, the sequencer
// and the flash-to-ICAP streamer.
interface reconf_sequencer_if;
  logic        req;
  logic [2:0]  slot;
  logic        running;
  logic        trigger;
  logic [23:0] addr;
  logic [23:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  req, slot, running,
    output trigger, addr, len, busy, done, err, err_code
  );

  modport master (
    output req, slot, running,
    input  trigger, addr, len, busy, done, err, err_code
  );
endinterface

// File: rtl/reconf_sequencer.sv
// Turns a slot request into one streamer launch (address/length/trigger) and
// supervises the streamer's running flag with start and run timeouts.
module reconf_sequencer #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter logic [23:0] SLOT_BASE   = 24'h100000,
  parameter logic [23:0] SLOT_STRIDE = 24'h080000,
  parameter logic [23:0] SLOT_LEN    = 24'h054000,
  parameter int unsigned START_TO    = 16,
  parameter logic [31:0] RUN_TO      = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst_b,
  reconf_sequencer_if.slave  bus
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SLOT_W = 4;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TO - 32'd1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SLOT  = 2'b01;
  localparam logic [1:0] ERR_START = 2'b10;
  localparam logic [1:0] ERR_RUN   = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    STREAM     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              trigger_q, trigger_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              slot_ok;
  logic [CNT_W-1:0]  cnt_inc;

  assign slot_ok = {1'b0, bus.slot} < SLOT_W'(NUM_SLOTS);
  // Saturating increment so a pathological timeout never wraps back to zero
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output decode; counter clears on every transition
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    len_d      = len_q;
    trigger_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req && !bus.running) begin
          if (slot_ok) begin
            addr_d    = SLOT_BASE + SLOT_STRIDE * ADDR_W'(bus.slot);
            len_d     = SLOT_LEN;
            trigger_d = 1'b1;
            state_d   = LAUNCH;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_SLOT;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.running) begin
          state_d = STREAM;
        end else if (cnt_q == START_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_START;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STREAM: begin
        if (!bus.running) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == RUN_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_RUN;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.trigger  = trigger_q;
  assign bus.addr     = addr_q;
  assign bus.len      = len_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule
